mem_wb_stage: RTL and testbench
===============================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have rst, input, 1, reset that is synchronous and active-high.
REQ-003 SHALL have in_valid, input, 1, an EX/MEM instruction is present.
REQ-004 SHALL have in_link, in_MemtoReg, in_MemRead, in_MemWrite, all input, 1 bit each, control bits from EX/MEM.
REQ-005 SHALL have in_PC_plus_two, in_XOut (ALU result / address) and in_WriteData, all input, 16 bits each.
REQ-006 SHALL have mem_en and mem_wr, output, 1 bit each, data-memory request pulse and write select.
REQ-007 SHALL have mem_addr and mem_data_in, output, 16 bits each, driven from the live request or the held request.
REQ-008 SHALL have mem_data_out, input, 16, and mem_done, input, 1, which is the read data / completion strobe.
REQ-009 SHALL have stall, output, 1, which tells upstream to hold its in_* signals stable.
REQ-010 SHALL have wb_valid, wb_link and wb_MemtoReg, output, 1 bit each, registered to the write-back stage.
REQ-011 SHALL have wb_PC_plus_two, wb_MemOut and wb_XOut, output, 16 bits each, registered to the write-back stage.
REQ-012 SHALL have err, output, 1, a sticky misaligned-access error.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, ERR.
REQ-014 SHALL define access = in_valid & (in_MemRead | in_MemWrite); misaligned = access & in_XOut[0].
REQ-015 In IDLE, access & ~misaligned SHALL assert mem_en=1 combinationally for that cycle only. mem_wr=in_MemWrite, mem_addr=in_XOut, mem_data_in=in_WriteData.
REQ-016 In IDLE with mem_done=1 in the issue cycle, the next edge SHALL load the wb_* registers with wb_MemOut=mem_data_out (read) or 0 (write), and wb_valid=1. State SHALL stay IDLE and stall SHALL stay 0.
REQ-017 In IDLE with mem_done=0 in the issue cycle, stall SHALL be 1 and the block SHALL capture addr/data/wr into holding registers. The next state SHALL be BUSY and wb_valid SHALL be 0 next cycle.
REQ-018 In BUSY, mem_en SHALL be 0 and mem_addr/mem_data_in/mem_wr SHALL drive the held values. stall = ~mem_done.
REQ-019 In BUSY with mem_done=1, the next edge SHALL load the wb_* registers from in_* plus mem_data_out, set wb_valid=1 and return to IDLE. stall SHALL already be 0 in the done cycle.
REQ-020 in_valid & ~access SHALL pass through in one cycle: wb_* = in_*, wb_MemOut=0, wb_valid=1, with no memory request.
REQ-021 in_valid=0 in IDLE SHALL load a bubble next edge: wb_valid=0, and all wb_* data SHALL hold their previous values.
REQ-022 A misaligned access SHALL issue no request (mem_en=0), set err=1 from the next edge, move to ERR and force wb_valid=0.
REQ-023 ERR SHALL be absorbing until rst, with stall=1, mem_en=0, wb_valid=0 and err=1.
REQ-024 mem_done in IDLE with no issue, or in ERR, SHALL be ignored.
REQ-025 A write access SHALL reach wb_valid=1 with wb_MemtoReg passed through unchanged; the write-back stage decides data selection.
REQ-026 There SHALL be no back-to-back overlap: at most one outstanding request.
REQ-027 Latency SHALL be 1 cycle for a non-memory op or a same-cycle done; otherwise it is 1 + the number of BUSY cycles until mem_done.

Reset
REQ-028 rst=1 at an edge SHALL force state=IDLE and all wb_* outputs to 0, including wb_valid=0, and err=0. Holding registers SHALL be cleared to 0.
REQ-029 While rst=1, mem_en SHALL be 0 and stall SHALL be 0 regardless of inputs.
REQ-030 rst asserted mid-BUSY SHALL abandon the request. A mem_done arriving after reset SHALL be ignored per REQ-024.

Verification
REQ-031 Pass-through: in_valid=1, no mem, in_XOut=0x1234, in_link=0 -> next cycle wb_valid=1, wb_XOut=0x1234, wb_MemOut=0, stall=0 throughout.
REQ-032 Single-cycle read: in_MemRead=1, in_XOut=0x0040, mem_done=1 with mem_data_out=0xBEEF in the same cycle -> mem_en pulse to addr 0x0040; next cycle wb_MemOut=0xBEEF, wb_valid=1.
REQ-033 Multi-cycle write: in_MemWrite=1, addr 0x0010, data 0x5A5A, mem_done after 3 cycles -> mem_en 1 cycle, stall=1 for 3 cycles, mem_addr held at 0x0010, then wb_valid=1 for exactly 1 cycle.
REQ-034 Misaligned: in_MemRead=1, in_XOut=0x0003 -> mem_en=0; err=1 from the next cycle, stall=1 and wb_valid=0 until rst.
REQ-035 Reset mid-BUSY: read issued, rst=1 on the 2nd BUSY cycle, then a late mem_done=1 -> state IDLE, wb_valid=0, all wb_* outputs=0, no write-back occurs.
REQ-036 Link: in_link=1, in_PC_plus_two=0x0102, no mem -> next cycle wb_link=1, wb_PC_plus_two=0x0102, wb_valid=1.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: issues at most one data-memory request per instruction,
// waits for completion, and registers the result for write-back.
module mem_wb_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        in_link,
    input  logic        in_MemtoReg,
    input  logic        in_MemRead,
    input  logic        in_MemWrite,
    input  logic [15:0] in_PC_plus_two,
    input  logic [15:0] in_XOut,
    input  logic [15:0] in_WriteData,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data_in,
    input  logic [15:0] mem_data_out,
    input  logic        mem_done,
    output logic        stall,
    output logic        wb_valid,
    output logic        wb_link,
    output logic        wb_MemtoReg,
    output logic [15:0] wb_PC_plus_two,
    output logic [15:0] wb_MemOut,
    output logic [15:0] wb_XOut,
    output logic        err,
    output logic [1:0]  dbg_state
);

    // Handshake: in_* is accepted on any edge where in_valid=1 and stall=0; while
    // stall=1 upstream holds in_* stable. mem_en is a one-cycle request pulse and
    // mem_done is the completion strobe, sampled only while a request is open.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        access;
    logic        misaligned;
    logic        issue;
    logic        complete;
    logic        mem_complete;
    logic        hold_wr;
    logic [15:0] hold_addr;
    logic [15:0] hold_data;

    always_comb begin
        access     = in_valid & (in_MemRead | in_MemWrite);
        misaligned = access & in_XOut[0];
        issue      = (state == IDLE) & access & ~misaligned & ~rst;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (misaligned)              state_nxt = ERR;
                else if (issue & ~mem_done)  state_nxt = BUSY;
            end
            BUSY:    if (mem_done) state_nxt = IDLE;
            ERR:     state_nxt = ERR;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_en       = 1'b0;
        mem_wr       = in_MemWrite;
        mem_addr     = in_XOut;
        mem_data_in  = in_WriteData;
        stall        = 1'b0;
        complete     = 1'b0;
        mem_complete = 1'b0;
        case (state)
            IDLE: begin
                mem_en       = issue;
                stall        = issue & ~mem_done;
                mem_complete = issue & mem_done;
                complete     = (in_valid & ~access) | mem_complete;
            end
            BUSY: begin
                mem_wr       = hold_wr;
                mem_addr     = hold_addr;
                mem_data_in  = hold_data;
                stall        = ~mem_done;
                mem_complete = mem_done;
                complete     = mem_done;
            end
            ERR:     stall = 1'b1;
            default: stall = 1'b0;
        endcase
        // Reset wins over everything so nothing leaks out while it is held.
        if (rst) begin
            mem_en       = 1'b0;
            stall        = 1'b0;
            complete     = 1'b0;
            mem_complete = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid       <= 1'b0;
            wb_link        <= 1'b0;
            wb_MemtoReg    <= 1'b0;
            wb_PC_plus_two <= 16'h0;
            wb_MemOut      <= 16'h0;
            wb_XOut        <= 16'h0;
            err            <= 1'b0;
            hold_wr        <= 1'b0;
            hold_addr      <= 16'h0;
            hold_data      <= 16'h0;
        end else begin
            wb_valid <= complete;
            if (complete) begin
                wb_link        <= in_link;
                wb_MemtoReg    <= in_MemtoReg;
                wb_PC_plus_two <= in_PC_plus_two;
                wb_XOut        <= in_XOut;
                wb_MemOut      <= (mem_complete & ~mem_wr) ? mem_data_out : 16'h0;
            end
            if (issue & ~mem_done) begin
                hold_wr   <= in_MemWrite;
                hold_addr <= in_XOut;
                hold_data <= in_WriteData;
            end
            if ((state == IDLE) & misaligned) err <= 1'b1;
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios plus randomized instruction stream,
// with a memory model, an expected-result queue and a decoupled write-back monitor.
module tb_mem_wb_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_link;
  logic        in_MemtoReg;
  logic        in_MemRead;
  logic        in_MemWrite;
  logic [15:0] in_PC_plus_two;
  logic [15:0] in_XOut;
  logic [15:0] in_WriteData;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_data_in;
  logic [15:0] mem_data_out;
  logic        mem_done;
  logic        stall;
  logic        wb_valid;
  logic        wb_link;
  logic        wb_MemtoReg;
  logic [15:0] wb_PC_plus_two;
  logic [15:0] wb_MemOut;
  logic [15:0] wb_XOut;
  logic        err;
  logic [1:0]  dbg_state;

  mem_wb_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_link(in_link),
    .in_MemtoReg(in_MemtoReg), .in_MemRead(in_MemRead), .in_MemWrite(in_MemWrite),
    .in_PC_plus_two(in_PC_plus_two), .in_XOut(in_XOut), .in_WriteData(in_WriteData),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_done(mem_done), .stall(stall),
    .wb_valid(wb_valid), .wb_link(wb_link), .wb_MemtoReg(wb_MemtoReg),
    .wb_PC_plus_two(wb_PC_plus_two), .wb_MemOut(wb_MemOut), .wb_XOut(wb_XOut),
    .err(err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard state ----------------
  // entry = {completion edge number[31:0], link, MemtoReg, PC+2, MemOut, XOut}
  logic [81:0] exp_q[$];
  logic [49:0] last_pkt;
  logic [15:0] mem_model [logic [15:0]];
  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [81:0] got, input logic [81:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
  endtask

  function automatic logic [81:0] pack(input bit link, input bit m2r, input logic [15:0] pc,
                                       input logic [15:0] memout, input logic [15:0] xout,
                                       input int c);
    return {32'(c), link, m2r, pc, memout, xout};
  endfunction

  function automatic logic [49:0] wb_now();
    return {wb_link, wb_MemtoReg, wb_PC_plus_two, wb_MemOut, wb_XOut};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (wb_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("wb_unexpected", 82'(1), 82'(0));
      end else begin
        chk("wb_result", {32'(cyc), wb_now()}, exp_q.pop_front());
      end
      last_pkt = wb_now();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_txn(input bit rd, input bit wr, input bit link, input bit m2r,
                        input logic [15:0] pc, input logic [15:0] xout,
                        input logic [15:0] wdata, input int lat);
    bit acc;
    logic [15:0] rdata;
    logic [15:0] memout;
    acc = rd | wr;
    if (rd && !mem_model.exists(xout)) mem_model[xout] = 16'($urandom);
    rdata  = rd ? mem_model[xout] : 16'($urandom);
    memout = (acc && !wr) ? rdata : 16'h0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_MemRead = rd; in_MemWrite = wr; in_link = link; in_MemtoReg = m2r;
    in_PC_plus_two = pc; in_XOut = xout; in_WriteData = wdata;
    mem_done     = acc ? (lat == 0) : 1'($urandom);
    mem_data_out = (acc && lat == 0) ? rdata : 16'($urandom);
    exp_q.push_back(pack(link, m2r, pc, memout, xout, cyc + 1 + (acc ? lat : 0)));
    #1;
    chk("issue_mem_en", 82'(mem_en), 82'(acc));
    chk("issue_stall", 82'(stall), 82'(acc && lat > 0));
    if (acc) begin
      chk("issue_addr", 82'(mem_addr), 82'(xout));
      chk("issue_wr", 82'(mem_wr), 82'(wr));
      chk("issue_data", 82'(mem_data_in), 82'(wdata));
    end
    if (acc) begin
      for (int k = 1; k <= lat; k++) begin
        @(posedge clk); #1;
        mem_done     = (k == lat);
        mem_data_out = (k == lat) ? rdata : 16'($urandom);
        // scramble the live bus in wait cycles; only the held request may reach memory
        in_XOut      = (k == lat) ? xout : 16'($urandom);
        in_WriteData = (k == lat) ? wdata : 16'($urandom);
        #1;
        chk("busy_mem_en", 82'(mem_en), 82'(0));
        chk("busy_stall", 82'(stall), 82'(k < lat));
        chk("busy_addr", 82'(mem_addr), 82'(xout));
        chk("busy_wr", 82'(mem_wr), 82'(wr));
        chk("busy_data", 82'(mem_data_in), 82'(wdata));
      end
    end
    if (wr) mem_model[xout] = wdata;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    in_valid = 1'b0; in_MemRead = 1'($urandom); in_MemWrite = 1'($urandom);
    in_link = 1'($urandom); in_MemtoReg = 1'($urandom);
    in_PC_plus_two = 16'($urandom); in_XOut = 16'($urandom); in_WriteData = 16'($urandom);
    mem_done = 1'($urandom); mem_data_out = 16'($urandom);
    #1;
    chk("idle_mem_en", 82'(mem_en), 82'(0));
    chk("idle_stall", 82'(stall), 82'(0));
    @(posedge clk); #3;
    chk("bubble_valid", 82'(wb_valid), 82'(0));
    chk("bubble_hold", 82'(wb_now()), 82'(last_pkt));
  endtask

  task automatic check_all_zero(input string name);
    chk(name, 82'({wb_valid, err, wb_now()}), 82'(0));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b1; in_MemRead = 1'b1; in_MemWrite = 1'b0;
    in_XOut = 16'h0040; mem_done = 1'b0;
    #1;
    chk("rst_mem_en", 82'(mem_en), 82'(0));
    chk("rst_stall", 82'(stall), 82'(0));
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    check_all_zero("rst_outputs");
    last_pkt = '0;
  endtask

  task automatic do_reset_mid_busy();
    @(posedge clk); #1;
    in_valid = 1'b1; in_MemRead = 1'b1; in_MemWrite = 1'b0; in_XOut = 16'h0080;
    in_link = 1'b1; in_MemtoReg = 1'b1; in_PC_plus_two = 16'h0222; mem_done = 1'b0;
    #1;
    chk("midrst_issue_en", 82'(mem_en), 82'(1));
    chk("midrst_issue_stall", 82'(stall), 82'(1));
    @(posedge clk); #1;
    #1 chk("midrst_busy1_stall", 82'(stall), 82'(1));
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_rst_mem_en", 82'(mem_en), 82'(0));
    chk("midrst_rst_stall", 82'(stall), 82'(0));
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; mem_done = 1'b1; mem_data_out = 16'hBEEF;
    check_all_zero("midrst_after_rst");
    #1;
    chk("midrst_late_done_en", 82'(mem_en), 82'(0));
    chk("midrst_late_done_stall", 82'(stall), 82'(0));
    @(posedge clk); #1;
    mem_done = 1'b0;
    check_all_zero("midrst_no_writeback");
    last_pkt = '0;
  endtask

  task automatic do_misaligned(input bit rd, input logic [15:0] xout);
    @(posedge clk); #1;
    in_valid = 1'b1; in_MemRead = rd; in_MemWrite = !rd; in_XOut = xout; mem_done = 1'b0;
    #1;
    chk("mis_mem_en", 82'(mem_en), 82'(0));
    chk("mis_err_before", 82'(err), 82'(0));
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_MemRead = 1'b1; in_MemWrite = 1'b0;
      in_XOut = 16'(2 * $urandom_range(0, 31)); mem_done = 1'($urandom);
      #1;
      chk("err_sticky", 82'(err), 82'(1));
      chk("err_stall", 82'(stall), 82'(1));
      chk("err_mem_en", 82'(mem_en), 82'(0));
      chk("err_wb_valid", 82'(wb_valid), 82'(0));
    end
  endtask

  task automatic random_txn();
    int kind;
    bit rd, wr;
    logic [15:0] xout;
    kind = $urandom_range(0, 9);
    if (kind < 2) begin
      idle_cycle();
    end else begin
      rd = (kind >= 4 && kind <= 6);
      wr = (kind >= 7);
      xout = (rd || wr) ? 16'(2 * $urandom_range(0, 15)) : 16'($urandom);
      do_txn(rd, wr, 1'($urandom), 1'($urandom), 16'($urandom), xout,
             16'($urandom), $urandom_range(0, 4));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_link = 1'b0; in_MemtoReg = 1'b0;
    in_MemRead = 1'b0; in_MemWrite = 1'b0; in_PC_plus_two = 16'h0; in_XOut = 16'h0;
    in_WriteData = 16'h0; mem_data_out = 16'h0; mem_done = 1'b0;
    last_pkt = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    chk("reset_mem_en", 82'(mem_en), 82'(0));
    chk("reset_stall", 82'(stall), 82'(0));
    rst = 1'b0;

    do_txn(0, 0, 0, 0, 16'h0000, 16'h1234, 16'h0000, 0);   // pass-through
    idle_cycle();
    do_txn(0, 0, 1, 0, 16'h0102, 16'h0000, 16'h0000, 0);   // link
    mem_model[16'h0040] = 16'hBEEF;
    do_txn(1, 0, 0, 1, 16'h0200, 16'h0040, 16'h0000, 0);   // same-cycle read
    do_txn(0, 1, 0, 1, 16'h0300, 16'h0010, 16'h5A5A, 3);   // multi-cycle write
    idle_cycle();
    do_txn(1, 0, 0, 1, 16'h0302, 16'h0010, 16'h0000, 1);   // read back the write
    do_txn(0, 0, 0, 0, 16'h0304, 16'h0003, 16'h0000, 0);   // odd XOut, no access
    idle_cycle();
    do_reset_mid_busy();

    for (int i = 0; i < 150; i++) random_txn();
    idle_cycle();

    do_misaligned(1'b1, 16'h0003);
    do_reset();
    for (int i = 0; i < 20; i++) random_txn();
    idle_cycle();
    repeat (2) @(posedge clk);
    chk("queue_drained", 82'(exp_q.size()), 82'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
